sasa_cam_arb: RTL and testbench
===============================

SASA_CAM_ARB -- requirements
Module: sasa_cam_arb

Interface
REQ-001 SHALL have parameter CAM_LEN, default 16: width of the CAM match vector.
REQ-002 SHALL have parameter CAM_LAT, default 2: cycles from cam_search to a valid cam_match; legal range 1-7.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester search request (bit i = requester i).
REQ-006 SHALL have ports req_key0 and req_key1  input  8  each, the search key of requester 0 and requester 1.
REQ-007 SHALL have port req_ready  output  2  one-hot request accept; transfer when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port rsp_valid  output  2  one-hot response valid for the owning requester.
REQ-009 SHALL have port rsp_match  output  CAM_LEN  captured match vector, shared by both requesters.
REQ-010 SHALL have port rsp_ack  input  2  per-requester response consume.
REQ-011 SHALL have port cam_key  output  8  key driven to the shared CAM.
REQ-012 SHALL have port cam_search  output  1  one-cycle CAM search strobe.
REQ-013 SHALL have port cam_match  input  CAM_LEN  CAM match vector.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SEARCH, WAIT and RESP.
REQ-016 IDLE: req_ready SHALL be the combinational one-hot grant among the asserted req_valid bits, and all-zero when none is asserted; req_ready SHALL be zero in every other state.
REQ-017 Arbitration SHALL be round-robin: a priority pointer names the preferred requester, the pointer resets to 0, and on each transfer it moves to the requester not granted.
REQ-018 With only one req_valid bit high, that requester SHALL be granted regardless of the pointer.
REQ-019 On transfer, the key of the granted requester and its id SHALL be registered, and the FSM SHALL move to SEARCH.
REQ-020 SEARCH lasts exactly 1 cycle: cam_search=1 and cam_key=registered key, then the FSM SHALL move to WAIT.
REQ-021 Outside SEARCH, cam_search SHALL be 0 and cam_key SHALL be 8'h00.
REQ-022 WAIT SHALL last exactly CAM_LAT cycles, counted by an internal 3-bit counter; cam_match SHALL be registered into rsp_match on the last WAIT edge (the cycle cam_search high + CAM_LAT), and the FSM SHALL then move to RESP.
REQ-023 cam_match SHALL be ignored in all other cycles.
REQ-024 RESP: rsp_valid[id]=1 and the other bit 0; rsp_valid and rsp_match SHALL hold stable until rsp_ack[id]=1, including an ack in the first RESP cycle; the FSM SHALL then move to IDLE.
REQ-025 Latency: transfer in cycle H -> cam_search in H+1 -> rsp_valid from H+2+CAM_LAT.
REQ-026 Minimum request-to-request spacing SHALL be CAM_LAT+3 cycles.
REQ-027 rsp_ack on the non-owning bit, or any rsp_ack outside RESP, SHALL be ignored.
REQ-028 rsp_match SHALL keep its last captured value after RESP until the next capture.
REQ-029 Dropping req_valid before req_ready is high SHALL cause no transfer and no state change.
REQ-030 Request inputs SHALL be ignored in SEARCH, WAIT and RESP; held requests are served later in IDLE.
REQ-031 req_key of the non-granted requester SHALL never reach cam_key.

Reset
REQ-032 On reset the block SHALL be in IDLE with pointer=0, WAIT counter=0, req_ready/rsp_valid=2'b00, rsp_match=0, cam_key=8'h00, cam_search=0 and busy=0.
REQ-033 Reset in any state SHALL abort the in-flight search without producing a response; a cam_match arriving after reset SHALL be ignored.

Verification
REQ-034 Single request, CAM_LAT=2: req_valid=01, key0=8'h5A, transfer at cycle 0 -> cam_search=1 with cam_key=8'h5A at cycle 1; drive cam_match=16'h0081 at cycle 3 -> rsp_valid=01, rsp_match=16'h0081 from cycle 4.
REQ-035 Contention: req_valid=11 after reset -> requester 0 granted first; both held -> requester 1 next, then 0; grant order 0,1,0.
REQ-036 Delayed ack: response held 5 cycles with rsp_ack=00 -> rsp_valid and rsp_match stable; rsp_ack=10 while owner is 0 -> ignored; rsp_ack=01 -> IDLE next cycle.
REQ-037 Reset mid-WAIT -> all outputs at reset values, no rsp_valid, and a later cam_match is not captured.
REQ-038 Back-to-back, CAM_LAT=1: requester 1 holds req_valid -> transfers exactly CAM_LAT+3=4 cycles apart with rsp_ack immediate.
REQ-039 CAM_LAT=7: cam_search to capture is exactly 7 cycles; cam_match=16'hFFFF at cycle 6 only is not captured.

Source files
------------

// File: rtl/sasa_cam_arb.sv
`timescale 1ns/1ps
// Purpose : round-robin arbiter sharing one fixed-latency CAM between two search requesters.
// Latency : transfer in cycle H -> cam_search in H+1 -> rsp_valid from H+2+CAM_LAT.
// Backpr. : one search in flight; req_ready only in IDLE, response held until the owner acks.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   req_valid/req_ready   per-requester search handshake (req_ready one-hot)
//   req_key0/req_key1     search keys of requester 0 / 1
//   rsp_valid/rsp_ack     one-hot response to the owning requester, consumed by its ack bit
//   rsp_match             captured CAM match vector (shared, holds until next capture)
//   cam_key/cam_search    key and one-cycle strobe to the shared CAM
//   cam_match             CAM result, valid CAM_LAT cycles after cam_search
//   busy                  high whenever the FSM is not IDLE
module sasa_cam_arb #(
    parameter int CAM_LEN = 16,
    parameter int CAM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [7:0]         req_key0,
    input  logic [7:0]         req_key1,
    output logic [1:0]         req_ready,
    output logic [1:0]         rsp_valid,
    output logic [CAM_LEN-1:0] rsp_match,
    input  logic [1:0]         rsp_ack,
    output logic [7:0]         cam_key,
    output logic               cam_search,
    input  logic [CAM_LEN-1:0] cam_match,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // WAIT counter value on the cycle the CAM result is valid.
    localparam logic [2:0] LP_LAST = 3'(CAM_LAT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_ptr;      // preferred requester on contention
    logic               r_id;       // owner of the in-flight search
    logic [7:0]         r_key;
    logic [2:0]         r_cnt;
    logic [CAM_LEN-1:0] r_match;

    logic [1:0]         w_gnt;
    logic               w_xfer;
    logic               w_last;

    // One-hot grant; the pointer only matters when both requesters are asking.
    always_comb begin
        w_gnt = 2'b00;
        case (req_valid)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    assign w_xfer = (r_state == S_IDLE) && (w_gnt != 2'b00);
    assign w_last = (r_state == S_WAIT) && (r_cnt == LP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        cam_search = 1'b0;
        cam_key    = 8'h00;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req_ready = w_gnt;
                if (w_gnt != 2'b00) begin
                    w_next = S_SEARCH;
                end
            end
            S_SEARCH: begin
                cam_search = 1'b1;
                cam_key    = r_key;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (w_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = r_id ? 2'b10 : 2'b01;
                // Only the owner's ack bit can release the response.
                if (rsp_ack[r_id]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_key   <= 8'h00;
            r_cnt   <= 3'd0;
            r_match <= '0;
        end else begin
            if (w_xfer) begin
                // Only the granted requester's key is ever latched.
                r_key <= w_gnt[1] ? req_key1 : req_key0;
                r_id  <= w_gnt[1];
                r_ptr <= ~w_gnt[1];
            end
            if (r_state == S_WAIT) begin
                r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
            end else begin
                r_cnt <= 3'd0;
            end
            // cam_match is sampled on exactly one edge per search.
            if (w_last) begin
                r_match <= cam_match;
            end
        end
    end

    assign rsp_match = r_match;

endmodule

// File: tb/tb_sasa_cam_arb.sv
`timescale 1ns/1ps
module tb_sasa_cam_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  rv  [3];
    logic [1:0]  rr  [3];
    logic [1:0]  rsv [3];
    logic [1:0]  ack [3];
    logic [7:0]  k0  [3];
    logic [7:0]  k1  [3];
    logic [7:0]  ck  [3];
    logic [15:0] rm  [3];
    logic [15:0] cm  [3];
    logic        cs  [3];
    logic        bz  [3];

    sasa_cam_arb #(.CAM_LEN(16), .CAM_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_key0(k0[0]), .req_key1(k1[0]),
        .req_ready(rr[0]), .rsp_valid(rsv[0]), .rsp_match(rm[0]), .rsp_ack(ack[0]),
        .cam_key(ck[0]), .cam_search(cs[0]), .cam_match(cm[0]), .busy(bz[0]));

    sasa_cam_arb #(.CAM_LEN(16), .CAM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_key0(k0[1]), .req_key1(k1[1]),
        .req_ready(rr[1]), .rsp_valid(rsv[1]), .rsp_match(rm[1]), .rsp_ack(ack[1]),
        .cam_key(ck[1]), .cam_search(cs[1]), .cam_match(cm[1]), .busy(bz[1]));

    sasa_cam_arb #(.CAM_LEN(16), .CAM_LAT(7)) u_lat7 (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .req_key0(k0[2]), .req_key1(k1[2]),
        .req_ready(rr[2]), .rsp_valid(rsv[2]), .rsp_match(rm[2]), .rsp_ack(ack[2]),
        .cam_key(ck[2]), .cam_search(cs[2]), .cam_match(cm[2]), .busy(bz[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          inst;
        logic [1:0]  vld;
        logic [15:0] match;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: each new response (rsp_valid rising) pops one expectation.
    bit seen [3];
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rsv[i] == 2'b00) begin
                seen[i] <= 1'b0;
            end else if (!seen[i]) begin
                seen[i] <= 1'b1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: inst %0d rsp_valid %b rsp_match %h, none expected", i, rsv[i], rm[i]);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_inst",  i,      e.inst);
                    chk("rsp_valid", rsv[i], e.vld);
                    chk("rsp_match", rm[i],  e.match);
                    chk("rsp_cycle", cyc,    e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction, starting and ending in an IDLE cycle (posedge+1).
    task automatic run_txn(input int i, input int lat, input logic [1:0] vld,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] gnt, input logic [15:0] m,
                           input bit hold, input int dly, output int h);
        exp_t       e;
        logic [7:0] key;
        key   = gnt[1] ? b : a;
        rv[i] = vld;
        k0[i] = a;
        k1[i] = b;
        #1;
        chk("req_ready_grant", rr[i], gnt);
        h       = cyc;
        e.inst  = i;
        e.vld   = gnt;
        e.match = m;
        e.cyc   = h + 2 + lat;
        sb.push_back(e);
        step();
        if (!hold) rv[i] = 2'b00;
        chk("cam_search", cs[i], 1);
        chk("cam_key", ck[i], key);
        chk("busy_search", bz[i], 1);
        chk("req_ready_busy", rr[i], 0);
        cm[i] = 16'hFFFF;
        for (int c = 1; c < lat; c++) begin
            step();
            chk("cam_search_wait", cs[i], 0);
            chk("cam_key_wait", ck[i], 0);
        end
        step();
        cm[i] = m;
        step();
        cm[i] = 16'hFFFF;
        for (int c = 0; c < dly; c++) begin
            chk("rsp_valid_hold", rsv[i], gnt);
            chk("rsp_match_hold", rm[i], m);
            ack[i] = ~gnt;
            step();
        end
        chk("rsp_valid_pre_ack", rsv[i], gnt);
        ack[i] = gnt;
        step();
        ack[i] = 2'b00;
        cm[i]  = 16'h0000;
        chk("busy_idle", bz[i], 0);
        chk("rsp_valid_idle", rsv[i], 0);
        chk("rsp_match_kept", rm[i], m);
    endtask

    task automatic chk_reset_vals(input int i);
        chk("rst_req_ready", rr[i], 0);
        chk("rst_rsp_valid", rsv[i], 0);
        chk("rst_rsp_match", rm[i], 0);
        chk("rst_cam_key", ck[i], 0);
        chk("rst_cam_search", cs[i], 0);
        chk("rst_busy", bz[i], 0);
    endtask

    initial begin
        int h, h1, h2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 2'b00; k0[i] = 8'h00; k1[i] = 8'h00;
            ack[i] = 2'b00; cm[i] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_reset_vals(i);
        reset = 1'b0;
        step();

        // Single request, key 5A, match 0081.
        run_txn(0, 2, 2'b01, 8'h5A, 8'h00, 2'b01, 16'h0081, 1'b0, 0, h);

        // Pointer now prefers 1, lone requester 0 still wins; delayed ack with wrong-bit acks.
        run_txn(0, 2, 2'b01, 8'h33, 8'hC4, 2'b01, 16'h1234, 1'b0, 5, h);

        // Reset during WAIT aborts the search; late cam_match is not captured.
        rv[0] = 2'b01; k0[0] = 8'h77;
        step();
        rv[0] = 2'b00;
        chk("abort_search", cs[0], 1);
        step();
        chk("abort_in_wait", bz[0], 1);
        reset = 1'b1;
        #1;
        chk_reset_vals(0);
        step();
        reset = 1'b0;
        cm[0] = 16'hAAAA;
        repeat (4) step();
        chk("abort_no_capture", rm[0], 0);
        chk("abort_idle", bz[0], 0);
        chk("abort_no_rsp", rsv[0], 0);
        cm[0] = 16'h0000;

        // Contention from reset: grant order 0,1,0 with both held.
        run_txn(0, 2, 2'b11, 8'h11, 8'h22, 2'b01, 16'h0101, 1'b1, 0, h);
        run_txn(0, 2, 2'b11, 8'h11, 8'h22, 2'b10, 16'h0202, 1'b1, 0, h);
        run_txn(0, 2, 2'b11, 8'h11, 8'h22, 2'b01, 16'h0303, 1'b0, 0, h);

        // Back-to-back at CAM_LAT=1: spacing is CAM_LAT+3 = 4.
        run_txn(1, 1, 2'b10, 8'hAA, 8'hBB, 2'b10, 16'h00F0, 1'b1, 0, h1);
        run_txn(1, 1, 2'b10, 8'hAA, 8'hBB, 2'b10, 16'h0F00, 1'b0, 0, h2);
        chk("b2b_spacing", h2 - h1, 4);

        // CAM_LAT=7: FFFF on non-capture cycles (including cycle 6) must not be captured.
        run_txn(2, 7, 2'b01, 8'hC3, 8'h3C, 2'b01, 16'h8001, 1'b0, 0, h);

        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
